// File: rtl/sprite_vram_scheduler.sv
// sprite_vram_scheduler: shares one single-port sprite VRAM between the
// scan-out read path and a buffered host write port. Display reads win
// every cycle the pixel is inside the sprite window; the buffered host
// write slips into the next cycle the window is not hit.
module sprite_vram_scheduler #(
    parameter int SPRITE_W   = 32,
    parameter int SPRITE_H   = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8,
    parameter int X_WIDTH    = 11,
    parameter int Y_WIDTH    = 10,
    parameter int SX_INIT    = 400,
    parameter int SY_INIT    = 300
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [X_WIDTH-1:0]    pixel_x,
    input  logic [Y_WIDTH-1:0]    pixel_y,
    input  logic                  video_enable,
    input  logic                  frame_start,
    input  logic                  pos_load,
    input  logic [X_WIDTH-1:0]    pos_x,
    input  logic [Y_WIDTH-1:0]    pos_y,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  sprite_hit
);

    // column offset occupies the low bits of the address, row offset the rest
    localparam int XB = $clog2(SPRITE_W);
    localparam int YB = ADDR_WIDTH - XB;

    typedef enum logic {IDLE, PEND} state_t;

    state_t                  state, state_d;
    logic [X_WIDTH-1:0]      sx, shadow_x;
    logic [Y_WIDTH-1:0]      sy, shadow_y;
    logic [ADDR_WIDTH-1:0]   buf_addr;
    logic [DATA_WIDTH-1:0]   buf_data;
    logic                    hit, hit_d1;
    logic                    capture, issue;
    logic [X_WIDTH:0]        x_end;
    logic [Y_WIDTH:0]        y_end;
    logic [XB-1:0]           off_x;
    logic [YB-1:0]           off_y;
    logic [ADDR_WIDTH-1:0]   rd_addr;

    // one extra bit on the window end so sx+SPRITE_W cannot wrap to a small value
    assign x_end = {1'b0, sx} + (X_WIDTH+1)'(SPRITE_W);
    assign y_end = {1'b0, sy} + (Y_WIDTH+1)'(SPRITE_H);

    assign hit = video_enable
              && ({1'b0, pixel_x} >= {1'b0, sx}) && ({1'b0, pixel_x} < x_end)
              && ({1'b0, pixel_y} >= {1'b0, sy}) && ({1'b0, pixel_y} < y_end);

    // offsets only need the bits that survive truncation to ADDR_WIDTH
    assign off_x   = pixel_x[XB-1:0] - sx[XB-1:0];
    assign off_y   = pixel_y[YB-1:0] - sy[YB-1:0];
    assign rd_addr = {off_y, off_x};

    // sprite origin: shadow follows pos_load, active origin only moves at frame_start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sx       <= X_WIDTH'(SX_INIT);
            sy       <= Y_WIDTH'(SY_INIT);
            shadow_x <= X_WIDTH'(SX_INIT);
            shadow_y <= Y_WIDTH'(SY_INIT);
        end else if (pos_load && frame_start) begin
            sx       <= pos_x;
            sy       <= pos_y;
            shadow_x <= pos_x;
            shadow_y <= pos_y;
        end else if (pos_load) begin
            shadow_x <= pos_x;
            shadow_y <= pos_y;
        end else if (frame_start) begin
            sx <= shadow_x;
            sy <= shadow_y;
        end
    end

    // write FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // write FSM: accept one request in IDLE, issue it on the first non-hit cycle
    always_comb begin
        state_d  = state;
        wr_ready = 1'b0;
        capture  = 1'b0;
        issue    = 1'b0;
        case (state)
            IDLE: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    capture = 1'b1;
                    state_d = PEND;
                end
            end
            PEND: begin
                if (!hit) begin
                    issue   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // VRAM port: display read has priority, otherwise the pending write, otherwise hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
            wr_done    <= 1'b0;
            hit_d1     <= 1'b0;
            sprite_hit <= 1'b0;
            buf_addr   <= '0;
            buf_data   <= '0;
        end else begin
            if (capture) begin
                buf_addr <= wr_addr;
                buf_data <= wr_data;
            end
            hit_d1     <= hit;
            sprite_hit <= hit_d1;
            wr_done    <= issue;
            if (hit) begin
                mem_addr <= rd_addr;
                mem_we   <= 1'b0;
            end else if (issue) begin
                mem_addr  <= buf_addr;
                mem_wdata <= buf_data;
                mem_we    <= 1'b1;
            end else begin
                mem_we <= 1'b0;
            end
        end
    end

endmodule
